// File: rtl/gan_pkg.sv
// Shared fixed-point constants, FSM encoding and weight-map sizing for the GAN sequencer.
package gan_pkg;

  localparam int unsigned Q_FRAC = 24;
  localparam logic [31:0] Q_ONE  = 32'(1) << Q_FRAC;
  localparam logic [31:0] Q_ZERO = 32'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GEN_MAC = 3'd1,
    S_GEN_ACT = 3'd2,
    S_DIS_MAC = 3'd3,
    S_DIS_ACT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Generator weights+bias per pixel, then one discriminator weight per pixel, then its bias.
  function automatic int unsigned nw_of(input int unsigned n_pix, input int unsigned n_in);
    return n_pix * (n_in + 1) + n_pix + 1;
  endfunction

endpackage

// File: rtl/gan_mac.sv
// Multiply-accumulate with fixed-point rescale, saturation and [0, 1.0] clamp.
module gan_mac import gan_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic             bias_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] act_c
);

  localparam int unsigned ACC_W = 2 * WIDTH + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  // 1.0 rescaled from the package's Q8.24 constant to this instance's FRAC.
  localparam logic signed [ACC_W-1:0] ONE   = (ACC_W'(Q_ONE) >> Q_FRAC) << FRAC;
  localparam logic [WIDTH-1:0]        ONE_W = WIDTH'(ONE);

  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   sh;
  logic signed [ACC_W-1:0]   sat;
  logic [WIDTH-1:0]          clamp;

  assign a_s  = op_a;
  assign b_s  = op_b;
  assign prod = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);

  always_comb begin
    term = bias_sel ? (ACC_W'(a_s) <<< FRAC) : ACC_W'(prod);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    sh = acc_q >>> FRAC;
    if (sh > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = sh;
    end
    if (sat[ACC_W-1]) begin
      clamp = '0;
    end else if (sat > ONE) begin
      clamp = ONE_W;
    end else begin
      clamp = sat[WIDTH-1:0];
    end
  end

  assign act_c = clamp;

endmodule

// File: rtl/gan_seq_core.sv
// Sequential 1-layer generator (N_IN latents -> N_PIX pixels) with optional 1-neuron discriminator.
module gan_seq_core import gan_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_PIX = 9
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       choice,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [N_IN*WIDTH-1:0]                      in_data,
  input  logic                                       wt_we,
  input  logic [$clog2(nw_of(N_PIX, N_IN))-1:0]      wt_addr,
  input  logic [WIDTH-1:0]                           wt_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [N_PIX*WIDTH-1:0]                     pixels,
  output logic [WIDTH-1:0]                           out_disc,
  output logic                                       busy
);

  localparam int unsigned NW     = nw_of(N_PIX, N_IN);
  localparam int unsigned AW     = $clog2(NW);
  localparam int unsigned CNT_W  = $clog2(((N_IN > N_PIX) ? N_IN : N_PIX) + 1);
  localparam int unsigned D_BASE = N_PIX * (N_IN + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        pix_q, pix_d;
  logic                    choice_q, choice_d;
  logic [N_IN*WIDTH-1:0]   lat_q, lat_d;
  logic [N_PIX*WIDTH-1:0]  pixels_q, pixels_d;
  logic [WIDTH-1:0]        disc_q, disc_d;
  logic [WIDTH-1:0]        wts_q [NW];
  logic [WIDTH-1:0]        wts_d [NW];
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic                    mac_clr, mac_en, is_bias, dis_phase;
  logic [AW-1:0]           rd_addr;
  logic [WIDTH-1:0]        rd_w, data_sel, op_a, act_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_valid) state_d = S_GEN_MAC;
      S_GEN_MAC: if (idx_q == CNT_W'(N_IN)) state_d = S_GEN_ACT;
      S_GEN_ACT: begin
        if (pix_q != CNT_W'(N_PIX - 1)) state_d = S_GEN_MAC;
        else if (choice_q)              state_d = S_DIS_MAC;
        else                            state_d = S_DONE;
      end
      S_DIS_MAC: if (idx_q == CNT_W'(N_PIX)) state_d = S_DIS_ACT;
      S_DIS_ACT: state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state; MAC controls follow the current state.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    mac_en      = (state_q == S_GEN_MAC) || (state_q == S_DIS_MAC);
    mac_clr     = (state_q == S_IDLE) || (state_q == S_GEN_ACT) || (state_q == S_DIS_ACT);
  end

  // Operand fetch: bias address follows the last weight, so one formula covers both.
  always_comb begin
    dis_phase = (state_q == S_DIS_MAC);
    if (dis_phase) begin
      rd_addr = AW'(D_BASE + 32'(idx_q));
      is_bias = (idx_q == CNT_W'(N_PIX));
    end else begin
      rd_addr = AW'(32'(pix_q) * (N_IN + 1) + 32'(idx_q));
      is_bias = (idx_q == CNT_W'(N_IN));
    end
    rd_w = '0;
    for (int k = 0; k < NW; k++) begin
      if (rd_addr == AW'(k)) rd_w = wts_q[k];
    end
    data_sel = '0;
    if (dis_phase) begin
      for (int k = 0; k < N_PIX; k++) begin
        if (idx_q == CNT_W'(k)) data_sel = pixels_q[k*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (idx_q == CNT_W'(k)) data_sel = lat_q[k*WIDTH +: WIDTH];
      end
    end
    op_a = is_bias ? rd_w : data_sel;
  end

  always_comb begin
    idx_d    = idx_q;
    pix_d    = pix_q;
    choice_d = choice_q;
    lat_d    = lat_q;
    pixels_d = pixels_q;
    disc_d   = disc_q;
    wts_d    = wts_q;
    unique case (state_q)
      S_IDLE: begin
        // Out-of-range addresses match no entry and are dropped.
        if (wt_we) begin
          for (int k = 0; k < NW; k++) begin
            if (wt_addr == AW'(k)) wts_d[k] = wt_data;
          end
        end
        if (in_valid) begin
          lat_d    = in_data;
          choice_d = choice;
          idx_d    = '0;
          pix_d    = '0;
        end
      end
      S_GEN_MAC: if (idx_q != CNT_W'(N_IN)) idx_d = idx_q + CNT_W'(1);
      S_GEN_ACT: begin
        idx_d = '0;
        for (int k = 0; k < N_PIX; k++) begin
          if (pix_q == CNT_W'(k)) pixels_d[k*WIDTH +: WIDTH] = act_c;
        end
        if (pix_q == CNT_W'(N_PIX - 1)) begin
          pix_d = '0;
          if (!choice_q) disc_d = WIDTH'(Q_ZERO);
        end else begin
          pix_d = pix_q + CNT_W'(1);
        end
      end
      S_DIS_MAC: if (idx_q != CNT_W'(N_PIX)) idx_d = idx_q + CNT_W'(1);
      S_DIS_ACT: disc_d = act_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      pix_q       <= '0;
      choice_q    <= 1'b0;
      lat_q       <= '0;
      pixels_q    <= '0;
      disc_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < NW; k++) wts_q[k] <= '0;
    end else begin
      idx_q       <= idx_d;
      pix_q       <= pix_d;
      choice_q    <= choice_d;
      lat_q       <= lat_d;
      pixels_q    <= pixels_d;
      disc_q      <= disc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int k = 0; k < NW; k++) wts_q[k] <= wts_d[k];
    end
  end

  gan_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .acc_en   (mac_en),
    .bias_sel (is_bias),
    .op_a     (op_a),
    .op_b     (rd_w),
    .act_c    (act_c)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pixels    = pixels_q;
  assign out_disc  = disc_q;

endmodule

// File: tb/tb_gan_seq_core.sv
// Directed bench for gan_seq_core with a per-cycle reference model of job timing and results.
module tb_gan_seq_core;

  localparam int W  = 32;
  localparam int FR = 24;
  localparam int NI = 2;
  localparam int NP = 9;
  localparam int NW = NP * (NI + 1) + NP + 1;
  localparam int AW = $clog2(NW);
  localparam int DB = NP * (NI + 1);
  localparam logic [31:0] ONE = 32'h0100_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              choice = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NI*W-1:0]   in_data = '0;
  logic              wt_we = 1'b0;
  logic [AW-1:0]     wt_addr = '0;
  logic [W-1:0]      wt_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NP*W-1:0]   pixels;
  logic [W-1:0]      out_disc;
  logic              busy;

  int total = 0;
  int bad   = 0;

  gan_seq_core #(.WIDTH(W), .FRAC(FR), .N_IN(NI), .N_PIX(NP)) dut (
    .clk(clk), .rst_n(rst_n), .choice(choice), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_ready(out_ready), .pixels(pixels), .out_disc(out_disc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NP*W-1:0] act, input logic [NP*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-job arithmetic from the weight map, latency from the job length formula.
  logic [31:0]     m_w [NW];
  logic            m_run, m_done;
  int              m_cnt, m_L;
  logic [NP*W-1:0] m_pix, m_epix;
  logic [31:0]     m_disc, m_edisc;

  function automatic logic [31:0] clampq(input logic signed [127:0] acc);
    logic signed [127:0] v;
    v = acc >>> FR;
    if (v < 0) return 32'd0;
    if (v > 128'sd16777216) return ONE;
    return v[31:0];
  endfunction

  function automatic logic [31:0] pix_of(input int p, input logic [NI*W-1:0] lat);
    logic signed [127:0] acc;
    logic signed [31:0] x, y;
    acc = 0;
    for (int i = 0; i < NI; i++) begin
      x = lat[32*i +: 32];
      y = m_w[p*(NI+1)+i];
      acc += 128'(x) * 128'(y);
    end
    y = m_w[p*(NI+1)+NI];
    acc += 128'(y) <<< FR;
    return clampq(acc);
  endfunction

  function automatic logic [31:0] disc_of(input logic [NI*W-1:0] lat);
    logic signed [127:0] acc;
    logic signed [31:0] x, y;
    acc = 0;
    for (int p = 0; p < NP; p++) begin
      x = pix_of(p, lat);
      y = m_w[DB+p];
      acc += 128'(x) * 128'(y);
    end
    y = m_w[NW-1];
    acc += 128'(y) <<< FR;
    return clampq(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_L    <= 0;
      m_pix  <= '0;
      m_epix <= '0;
      m_disc <= '0;
      m_edisc <= '0;
      for (int k = 0; k < NW; k++) m_w[k] <= '0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_L) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_pix  <= m_epix;
        m_disc <= m_edisc;
      end
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else begin
      if (wt_we && int'(wt_addr) < NW) m_w[wt_addr] <= wt_data;
      if (in_valid) begin
        m_run <= 1'b1;
        m_cnt <= 0;
        m_L   <= NP * (NI + 2) + (choice ? NP + 2 : 0);
        for (int p = 0; p < NP; p++) m_epix[p*32 +: 32] <= pix_of(p, in_data);
        m_edisc <= choice ? disc_of(in_data) : 32'd0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pixels", pixels, 0);
      chk("rst_out_disc", out_disc, 0);
    end else begin
      chk("busy", busy, m_run | m_done);
      chk("in_ready", in_ready, !(m_run | m_done));
      chk("out_valid", out_valid, m_done);
      if (!m_run) begin
        chk("pixels", pixels, m_pix);
        chk("out_disc", out_disc, m_disc);
      end
    end
  end

  task automatic wr(input int addr, input logic [31:0] data);
    wt_we = 1'b1;
    wt_addr = AW'(addr);
    wt_data = data;
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic set_gen(input logic [31:0] g0);
    for (int p = 0; p < NP; p++) begin
      wr(p*(NI+1), g0);
      wr(p*(NI+1)+1, 32'd0);
      wr(p*(NI+1)+2, 32'd0);
    end
  endtask

  // Returns the number of edges from acceptance to the first edge showing out_valid.
  task automatic run_job(input logic [31:0] l0, input logic [31:0] l1, input logic ch, output int n);
    in_data = {l1, l0};
    choice = ch;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL job_timeout: got no out_valid within %0d edges want latency %0d", n, ch ? 47 : 36);
    end
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int vcnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pin_in_ready_after_reset", in_ready, 1);
    chk("pin_busy_after_reset", busy, 0);

    // Generator: pixel = latent0
    set_gen(ONE);
    run_job(32'd0, ONE, 1'b0, lat);
    chk("pin_gen_zero_pixels", pixels, 0);
    chk("pin_gen_latency0_a", lat, 36);
    run_job(ONE, 32'd0, 1'b0, lat);
    chk("pin_gen_one_pixels", pixels, {NP{ONE}});
    chk("pin_gen_latency0_b", lat, 36);
    chk("pin_gen_disc_zero", out_disc, 0);

    // Discriminator: 9 * 1.0 * 0.125 - 0.5 = 0.625
    for (int p = 0; p < NP; p++) wr(DB + p, 32'h0020_0000);
    wr(NW - 1, 32'hFF80_0000);
    wr(NW + 5, 32'hDEAD_BEEF);
    run_job(ONE, 32'd0, 1'b1, lat);
    chk("pin_disc_score", out_disc, 32'h00A0_0000);
    chk("pin_disc_latency1", lat, 47);
    run_job(ONE, 32'd0, 1'b0, lat);
    chk("pin_disc_cleared_choice0", out_disc, 0);

    // Saturation both ways
    set_gen(32'h7F00_0000);
    run_job(32'h7F00_0000, 32'd0, 1'b0, lat);
    chk("pin_sat_pos", pixels, {NP{ONE}});
    run_job(32'h8100_0000, 32'd0, 1'b0, lat);
    chk("pin_sat_neg", pixels, 0);

    // Backpressure: held result, ignored job request and weight write
    out_ready = 1'b0;
    run_job(ONE, 32'd0, 1'b1, lat);
    chk("pin_bp_disc", out_disc, 32'h00A0_0000);
    in_valid = 1'b1;
    choice = 1'b0;
    wt_we = 1'b1;
    wt_addr = '0;
    wt_data = 32'hF000_0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("pin_bp_out_valid", out_valid, 1);
      chk("pin_bp_in_ready", in_ready, 0);
      chk("pin_bp_pixels", pixels, {NP{ONE}});
    end
    in_valid = 1'b0;
    wt_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pin_bp_released", in_ready, 1);
    run_job(ONE, 32'd0, 1'b0, lat);
    chk("pin_bp_weight_kept", pixels, {NP{ONE}});

    // Reset in the middle of a discriminator job
    in_data = {32'd0, ONE};
    choice = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("pin_midrst_busy", busy, 0);
    chk("pin_midrst_out_valid", out_valid, 0);
    chk("pin_midrst_pixels", pixels, 0);
    chk("pin_midrst_disc", out_disc, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    chk("pin_midrst_no_valid", vcnt, 0);
    run_job(ONE, ONE, 1'b1, lat);
    chk("pin_midrst_weights_zero", pixels, 0);
    chk("pin_midrst_disc_zero", out_disc, 0);
    chk("pin_midrst_latency1", lat, 47);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
